seg_frame_driver: RTL and testbench

Display-side companion to the digit-scan FSM on the multiplexed seven-segment path. Divides the system clock to produce the `slow_clock` that steps the scan FSM, double-buffers a 16-bit result word (four hex digits) from the adder/subtractor, and swaps it into the displayed buffer only at a frame boundary, so a digit frame never mixes two words. It consumes the FSM's `SEL` and drives the registered, active-low segment pattern for the selected digit.

---
 rtl/seg_frame_driver.sv | 123 ++++++++++++
 tb/tb_seg_frame_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_driver.sv
// Seven-segment frame driver: clock divider for the scan FSM, double-buffered hex word, registered active-low decode.
// Latency: SEG follows SEL by one clock; a loaded word appears at the next frame boundary (<= 8*DIV+1 cycles).
// Backpressure: none, load is always accepted (last word wins); ready is advisory. Option: SEG_LEADING_ZERO_BLANK_EN.
module seg_frame_driver #(
    parameter int unsigned DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [1:0]  SEL,
    output logic        slow_clock,
    output logic        ready,
    output logic [6:0]  SEG
);

    localparam logic [19:0] CNT_MAX = 20'(DIV - 1);
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    logic [19:0] cnt;
    logic [15:0] shadow;
    logic [15:0] active;
    logic        pending;
    logic        wrap;
    logic        swap;
    logic [3:0]  nib;
    logic        blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign wrap  = (cnt == CNT_MAX);
    // Last cycle of digit 3: the falling edge that follows moves the scan FSM back to digit 0.
    assign swap  = wrap && slow_clock && (SEL == 2'b11) && pending;
    assign ready = !pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            slow_clock <= 1'b0;
        end else if (wrap) begin
            cnt        <= '0;
            slow_clock <= !slow_clock;
        end else begin
            cnt        <= cnt + 20'd1;
        end
    end

    // A load coinciding with a swap keeps pending set: the new word waits for the next frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= din;
            end
            if (swap) begin
                active <= shadow;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        nib = active[15:12];
        case (SEL)
            2'd0:    nib = active[15:12];
            2'd1:    nib = active[11:8];
            2'd2:    nib = active[7:4];
            default: nib = active[3:0];
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Rightmost digit is never blanked so an all-zero word still shows a single 0.
    always_comb begin
        blank = 1'b0;
        case (SEL)
            2'd0:    blank = (active[15:12] == 4'h0);
            2'd1:    blank = (active[15:8] == 8'h00);
            2'd2:    blank = (active[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            SEG <= SEG_OFF;
        end else begin
            SEG <= blank ? SEG_OFF : hex7(nib);
        end
    end

endmodule

// File: tb/tb_seg_frame_driver.sv
// Directed bench for seg_frame_driver with DIV=4 and a behavioural digit-scan FSM stepping SEL on slow_clock falling edges.
module tb_seg_frame_driver;

    localparam int DIV = 4;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [27:0] EXP_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] EXP_0A05 = {7'h7F, 7'h08, 7'h40, 7'h12};
`else
    localparam logic [27:0] EXP_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] EXP_0A05 = {7'h40, 7'h08, 7'h40, 7'h12};
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] din   = 16'h0000;
    logic [1:0]  sel   = 2'd0;
    logic        slow_clock;
    logic        ready;
    logic [6:0]  seg;

    int vectors     = 0;
    int miscompares = 0;
    int frame_cnt   = 0;
    logic [27:0] frm;

    seg_frame_driver #(.DIV(DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .din       (din),
        .SEL       (sel),
        .slow_clock(slow_clock),
        .ready     (ready),
        .SEG       (seg)
    );

    always #5 clock = ~clock;

    // Scan FSM model: digit advances on each slow_clock falling edge, frame counted on 3 -> 0.
    always @(negedge slow_clock or negedge reset) begin
        if (!reset) begin
            sel = 2'd0;
        end else begin
            sel = sel + 2'd1;
            if (sel == 2'd0) frame_cnt = frame_cnt + 1;
        end
    end

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1;
        din  = v;
        @(negedge clock);
        load = 1'b0;
        din  = 16'h0000;
    endtask

    task automatic sync_frame();
        int  start;
        bit  done;
        start = frame_cnt;
        done  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (frame_cnt != start) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL sync_frame: no frame start within 80 cycles, frame_cnt=%0d expected >%0d", frame_cnt, start);
        end
    endtask

    task automatic wait_sel(input logic [1:0] v);
        for (int i = 0; i < 40; i++) begin
            if (sel == v) break;
            @(negedge clock);
        end
        if (sel != v) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_sel: SEL=%0d expected %0d", sel, v);
        end
    endtask

    // Starts just after a frame-start edge, ends just after the next one.
    task automatic capture_frame(output logic [27:0] f);
        f = '0;
        for (int d = 0; d < 4; d++) begin
            repeat (3) @(negedge clock);
            f[27-7*d -: 7] = seg;
            repeat (5) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL rst_seg: got %h want 7f", seg); end
        vectors++; if (slow_clock !== 1'b0) begin miscompares++; $display("FAIL rst_slow: got %b want 0", slow_clock); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", ready); end
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (seg !== EXP_ZERO[27:21]) begin miscompares++; $display("FAIL rst_first_seg: got %h want %h", seg, EXP_ZERO[27:21]); end
        repeat (2) @(negedge clock);
        vectors++; if (slow_clock !== 1'b0) begin miscompares++; $display("FAIL slow_edge3: got %b want 0", slow_clock); end
        @(negedge clock);
        vectors++; if (slow_clock !== 1'b1) begin miscompares++; $display("FAIL slow_edge4: got %b want 1", slow_clock); end
        repeat (3) @(negedge clock);
        vectors++; if (slow_clock !== 1'b1) begin miscompares++; $display("FAIL slow_edge7: got %b want 1", slow_clock); end
        @(negedge clock);
        vectors++; if (slow_clock !== 1'b0) begin miscompares++; $display("FAIL slow_edge8: got %b want 0", slow_clock); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_run: got %b want 1", ready); end
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== EXP_ZERO) begin miscompares++; $display("FAIL rst_frame: got %h want %h", frm, EXP_ZERO); end
    endtask

    task automatic test_load_swap();
        wait_sel(2'd1);
        pulse_load(16'h1234);
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL ls_ready_lo: got %b want 0", ready); end
        wait_sel(2'd2);
        repeat (3) @(negedge clock);
        vectors++; if (seg !== EXP_ZERO[13:7]) begin miscompares++; $display("FAIL ls_hold_d2: got %h want %h", seg, EXP_ZERO[13:7]); end
        wait_sel(2'd3);
        repeat (3) @(negedge clock);
        vectors++; if (seg !== EXP_ZERO[6:0]) begin miscompares++; $display("FAIL ls_hold_d3: got %h want %h", seg, EXP_ZERO[6:0]); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL ls_ready_pre: got %b want 0", ready); end
        sync_frame();
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL ls_ready_post: got %b want 1", ready); end
        capture_frame(frm);
        vectors++; if (frm !== {7'h79, 7'h24, 7'h30, 7'h19}) begin miscompares++; $display("FAIL ls_frame: got %h want %h", frm, {7'h79, 7'h24, 7'h30, 7'h19}); end
    endtask

    task automatic test_two_loads();
        pulse_load(16'hAAAA);
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL tl_ready: got %b want 0", ready); end
        wait_sel(2'd2);
        pulse_load(16'hBEEF);
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== {7'h03, 7'h06, 7'h06, 7'h0E}) begin miscompares++; $display("FAIL tl_frame1: got %h want %h", frm, {7'h03, 7'h06, 7'h06, 7'h0E}); end
        capture_frame(frm);
        vectors++; if (frm !== {7'h03, 7'h06, 7'h06, 7'h0E}) begin miscompares++; $display("FAIL tl_frame2: got %h want %h", frm, {7'h03, 7'h06, 7'h06, 7'h0E}); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL tl_ready_end: got %b want 1", ready); end
    endtask

    task automatic test_load_on_swap();
        pulse_load(16'h1111);
        repeat (30) @(negedge clock);
        load = 1'b1;
        din  = 16'h5555;
        @(negedge clock);
        load = 1'b0;
        din  = 16'h0000;
        vectors++; if (sel !== 2'd0) begin miscompares++; $display("FAIL los_sel: got %0d want 0", sel); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL los_pending: ready got %b want 0", ready); end
        capture_frame(frm);
        vectors++; if (frm !== {4{7'h79}}) begin miscompares++; $display("FAIL los_frame1: got %h want %h", frm, {4{7'h79}}); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL los_ready2: got %b want 1", ready); end
        capture_frame(frm);
        vectors++; if (frm !== {4{7'h12}}) begin miscompares++; $display("FAIL los_frame2: got %h want %h", frm, {4{7'h12}}); end
    endtask

    task automatic test_reset_mid();
        pulse_load(16'hCAFE);
        wait_sel(2'd2);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL rm_seg: got %h want 7f", seg); end
        vectors++; if (slow_clock !== 1'b0) begin miscompares++; $display("FAIL rm_slow: got %b want 0", slow_clock); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready: got %b want 1", ready); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (seg !== EXP_ZERO[27:21]) begin miscompares++; $display("FAIL rm_resume: got %h want %h", seg, EXP_ZERO[27:21]); end
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== EXP_ZERO) begin miscompares++; $display("FAIL rm_frame: got %h want %h", frm, EXP_ZERO); end
    endtask

    task automatic test_decode();
        pulse_load(16'h6789);
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== {7'h02, 7'h78, 7'h00, 7'h10}) begin miscompares++; $display("FAIL dec_6789: got %h want %h", frm, {7'h02, 7'h78, 7'h00, 7'h10}); end
        pulse_load(16'hCDEF);
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== {7'h46, 7'h21, 7'h06, 7'h0E}) begin miscompares++; $display("FAIL dec_cdef: got %h want %h", frm, {7'h46, 7'h21, 7'h06, 7'h0E}); end
    endtask

    task automatic test_blank();
        pulse_load(16'h0000);
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== EXP_ZERO) begin miscompares++; $display("FAIL blank_0000: got %h want %h", frm, EXP_ZERO); end
        pulse_load(16'h0A05);
        sync_frame();
        capture_frame(frm);
        vectors++; if (frm !== EXP_0A05) begin miscompares++; $display("FAIL blank_0a05: got %h want %h", frm, EXP_0A05); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_swap();
        test_two_loads();
        test_load_on_swap();
        test_reset_mid();
        test_decode();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
